// File: rtl/l2_cache_wb.sv
`default_nettype none
// ============================================================================
//  Module   : l2_cache_wb
//  Purpose  : Set-associative, write-back / write-allocate line cache with a
//             per-set round-robin victim pointer and one outstanding request.
//  Revision : 1.0  initial release
// ============================================================================

module l2_cache_wb #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  input  logic                              req_write,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] req_wdata,
  output logic                              req_ready,
  output logic                              resp_valid,
  output logic                              resp_hit,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_wdata,
  output logic                              mem_read,
  output logic                              mem_write,
  input  logic                              mem_ack,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]                       hit_count,
  output logic [31:0]                       miss_count
);

  localparam int LINE_W = BLOCK_WORDS * DATA_WIDTH;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int LIX_W  = IDX_W + WAY_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [LINE_W-1:0]       wdata_q, wdata_d;
  logic [WAY_W-1:0]        way_q, way_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_hit_q, resp_hit_d;
  logic [LINE_W-1:0]       resp_rdata_q, resp_rdata_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [31:0]             hit_count_q, hit_count_d;
  logic [31:0]             miss_count_q, miss_count_d;

  logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]     valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0]     dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0]     dirty_d [NUM_SETS];
  logic [WAY_W-1:0]        ptr_q   [NUM_SETS];
  logic [WAY_W-1:0]        ptr_d   [NUM_SETS];

  // Tag and data storage; flattened as {index, way}, intentionally not reset.
  logic [TAG_W-1:0]        tag_mem  [NUM_SETS*NUM_WAYS];
  logic [LINE_W-1:0]       data_mem [NUM_SETS*NUM_WAYS];

  logic                    line_we;
  logic [LIX_W-1:0]        line_ix;
  logic [LINE_W-1:0]       line_data;
  logic [TAG_W-1:0]        line_tag;

  logic [IDX_W-1:0]        req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    hit;
  logic [WAY_W-1:0]        hit_way;
  logic                    has_inv;
  logic [WAY_W-1:0]        inv_way;
  logic [WAY_W-1:0]        victim;
  logic                    go_next;
  logic [WAY_W-1:0]        fill_way;
  logic                    unused_off;

  assign req_idx    = addr_q[OFF_W +: IDX_W];
  assign req_tag    = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign unused_off = ^addr_q[OFF_W-1:0];
  assign victim     = has_inv ? inv_way : ptr_q[req_idx];

  // Tag compare across every way of the latched set, plus lowest free way.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][WAY_W'(w)] &&
          tag_mem[{req_idx, WAY_W'(w)}] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][WAY_W'(w)]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  // Next-state, registered-output and line-install decisions.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    way_d        = way_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    ptr_d        = ptr_q;
    line_we      = 1'b0;
    line_ix      = {req_idx, way_q};
    line_data    = wdata_q;
    line_tag     = req_tag;
    go_next      = 1'b0;
    fill_way     = way_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
          way_d        = hit_way;
          resp_hit_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = RESPOND;
          if (write_q) begin
            line_we                   = 1'b1;
            line_ix                   = {req_idx, hit_way};
            dirty_d[req_idx][hit_way] = 1'b1;
          end else begin
            resp_rdata_d = data_mem[{req_idx, hit_way}];
          end
        end else begin
          if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
          way_d      = victim;
          resp_hit_d = 1'b0;
          if (!has_inv) ptr_d[req_idx] = ptr_q[req_idx] + 1'b1;
          if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_mem[{req_idx, victim}], req_idx, {OFF_W{1'b0}}};
            mem_wdata_d = data_mem[{req_idx, victim}];
            state_d     = WRITEBACK;
          end else begin
            go_next  = 1'b1;
            fill_way = victim;
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          mem_write_d             = 1'b0;
          dirty_d[req_idx][way_q] = 1'b0;
          go_next                 = 1'b1;
          fill_way                = way_q;
        end
      end
      ALLOCATE: begin
        if (mem_ack) begin
          mem_read_d              = 1'b0;
          line_we                 = 1'b1;
          line_data               = mem_rdata;
          valid_d[req_idx][way_q] = 1'b1;
          dirty_d[req_idx][way_q] = 1'b0;
          resp_rdata_d            = mem_rdata;
          resp_hit_d              = 1'b0;
          resp_valid_d            = 1'b1;
          state_d                 = RESPOND;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Victim is free: a write miss installs directly, a read miss fetches.
    if (go_next) begin
      if (write_q) begin
        line_we                    = 1'b1;
        line_ix                    = {req_idx, fill_way};
        line_data                  = wdata_q;
        valid_d[req_idx][fill_way] = 1'b1;
        dirty_d[req_idx][fill_way] = 1'b1;
        resp_valid_d               = 1'b1;
        state_d                    = RESPOND;
      end else begin
        mem_read_d = 1'b1;
        mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
        state_d    = ALLOCATE;
      end
    end
  end

  // Control state, line status bits and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      way_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      valid_q      <= '{default: '0};
      dirty_q      <= '{default: '0};
      ptr_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      way_q        <= way_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      ptr_q        <= ptr_d;
    end
  end

  // Line tag/data write port.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[line_ix]  <= line_tag;
      data_mem[line_ix] <= line_data;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

`default_nettype wire

// File: tb/tb_l2_cache_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_cache_wb
//  Purpose  : Randomized self-checking bench for l2_cache_wb with a
//             line-level cache/memory reference model.
//  Revision : 1.0  initial release
// ============================================================================

module tb_l2_cache_wb;

  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_write, req_ready;
  logic [31:0]   req_addr;
  logic [LW-1:0] req_wdata;
  logic          resp_valid, resp_hit;
  logic [LW-1:0] resp_rdata;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          mem_read, mem_write, mem_ack;
  logic [31:0]   hit_count, miss_count;

  always #5 clk = ~clk;

  l2_cache_wb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference cache contents (16 sets x 4 ways) and backing memory by line.
  bit            m_valid [16][4];
  bit            m_dirty [16][4];
  logic [21:0]   m_tag   [16][4];
  logic [LW-1:0] m_data  [16][4];
  int            m_ptr   [16];
  int            m_hits, m_misses;
  logic [LW-1:0] bmem [logic [31:0]];

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // One request: predict from the model, drive it, service memory, check.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [LW-1:0] wd,
                        input bit hold, output bit o_hit, output int o_wb, output int o_rd);
    int            idx, hw, v, k;
    logic [21:0]   tg;
    logic [31:0]   la, wb_addr, op_addr;
    logic [LW-1:0] exp_rd, wb_data;
    bit            exp_hit, exp_wb, exp_fill, done, adv, is_wr;
    idx = int'(a[9:6]);
    tg  = a[31:10];
    la  = {a[31:6], 6'b0};
    hw  = -1;
    for (int w = 0; w < 4; w++) if (m_valid[idx][w] && m_tag[idx][w] == tg) hw = w;
    exp_hit = (hw >= 0); exp_wb = 1'b0; exp_fill = 1'b0;
    exp_rd = '0; wb_addr = '0; wb_data = '0;
    if (exp_hit) begin
      m_hits++;
      if (wr) begin
        m_data[idx][hw]  = wd;
        m_dirty[idx][hw] = 1'b1;
      end else begin
        exp_rd = m_data[idx][hw];
      end
    end else begin
      m_misses++;
      v = -1;
      for (int w = 3; w >= 0; w--) if (!m_valid[idx][w]) v = w;
      if (v < 0) begin
        v = m_ptr[idx];
        m_ptr[idx] = (m_ptr[idx] + 1) % 4;
      end
      if (m_valid[idx][v] && m_dirty[idx][v]) begin
        exp_wb  = 1'b1;
        wb_addr = {m_tag[idx][v], a[9:6], 6'b0};
        wb_data = m_data[idx][v];
        bmem[wb_addr] = wb_data;
      end
      m_valid[idx][v] = 1'b1;
      m_tag[idx][v]   = tg;
      if (wr) begin
        m_data[idx][v]  = wd;
        m_dirty[idx][v] = 1'b1;
      end else begin
        exp_fill = 1'b1;
        if (!bmem.exists(la)) bmem[la] = rand_line();
        exp_rd = bmem[la];
        m_data[idx][v]  = exp_rd;
        m_dirty[idx][v] = 1'b0;
      end
    end

    o_hit = 1'b0; o_wb = 0; o_rd = 0;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    check("ready_wait", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    k = 1; done = 1'b0;
    while (!done && k < 300) begin
      adv = 1'b1;
      if (mem_read && mem_write) check("mem_both", 1, 0);
      if (hold && !resp_valid) check("hold_ready_low", req_ready, 0);
      if (resp_valid) begin
        done  = 1'b1;
        o_hit = resp_hit;
        check("resp_hit", resp_hit, exp_hit);
        if (!wr) check("resp_rdata", resp_rdata, exp_rd);
        if (exp_hit) check("hit_latency", k, 2);
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        check("mem_idle_at_resp", {mem_read, mem_write}, 0);
        if (hold) req_valid = 1'b0;
      end else if (mem_read || mem_write) begin
        is_wr   = mem_write;
        op_addr = mem_addr;
        if (is_wr) begin
          o_wb++;
          check("wb_expected", exp_wb, 1);
          check("wb_addr", mem_addr, wb_addr);
          check("wb_data", mem_wdata, wb_data);
        end else begin
          o_rd++;
          check("fill_expected", exp_fill, 1);
          check("fill_after_wb", o_wb, exp_wb);
          check("fill_addr", mem_addr, la);
        end
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk); k++;
          check("mem_addr_stable", mem_addr, op_addr);
          check("mem_req_held", is_wr ? mem_write : mem_read, 1);
        end
        mem_ack   = 1'b1;
        mem_rdata = is_wr ? rand_line() : exp_rd;
        @(negedge clk); k++;
        mem_ack   = 1'b0;
        mem_rdata = rand_line();
        check("mem_deassert", is_wr ? mem_write : mem_read, 0);
        adv = 1'b0;
      end
      if (!done && adv) begin @(negedge clk); k++; end
    end
    if (!done) check("resp_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          h;
    int          nwb, nrd, k, tgi;
    logic [31:0] a;
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_rw", {mem_read, mem_write}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_counters", {hit_count, miss_count}, 0);
    check("rst_rdata", resp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    // Cold read miss then re-read hit.
    do_req(1'b0, 32'h0000_1040, '0, 1'b0, h, nwb, nrd);
    check("t23_hit", h, 0);
    check("t23_fill", nrd, 1);
    check("t23_wb", nwb, 0);
    check("t23_miss_count", miss_count, 1);
    do_req(1'b0, 32'h0000_1040, '0, 1'b0, h, nwb, nrd);
    check("t23_rehit", h, 1);
    check("t23_refill", nrd, 0);

    // Write miss installs directly.
    do_req(1'b1, 32'h0000_0080, rand_line(), 1'b0, h, nwb, nrd);
    check("t24_hit", h, 0);
    check("t24_memops", nwb + nrd, 0);
    do_req(1'b0, 32'h0000_0080, '0, 1'b0, h, nwb, nrd);
    check("t24_read_hit", h, 1);

    // Dirty eviction write-back.
    apply_reset();
    do_req(1'b1, 32'h0000_0040, rand_line(), 1'b0, h, nwb, nrd);
    for (int i = 1; i < 4; i++) do_req(1'b0, 32'h0000_0040 + i * 32'h400, '0, 1'b0, h, nwb, nrd);
    do_req(1'b0, 32'h0000_1040, '0, 1'b0, h, nwb, nrd);
    check("t25_wb", nwb, 1);
    check("t25_fill", nrd, 1);
    do_req(1'b0, 32'h0000_0040, '0, 1'b0, h, nwb, nrd);
    check("t25_evicted", h, 0);

    // Round-robin replacement on a clean full set.
    apply_reset();
    for (int i = 0; i < 4; i++) do_req(1'b0, 32'h0000_0040 + i * 32'h400, '0, 1'b0, h, nwb, nrd);
    for (int i = 4; i < 9; i++) begin
      do_req(1'b0, 32'h0000_0040 + i * 32'h400, '0, 1'b0, h, nwb, nrd);
      check("t26_miss", h, 0);
      check("t26_no_wb", nwb, 0);
    end
    for (int i = 5; i < 9; i++) begin
      do_req(1'b0, 32'h0000_0040 + i * 32'h400, '0, 1'b0, h, nwb, nrd);
      check("t26_resident", h, 1);
    end
    do_req(1'b0, 32'h0000_1040, '0, 1'b0, h, nwb, nrd);
    check("t26_gone", h, 0);

    // Reset during ALLOCATE.
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_3040;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!mem_read && k < 20) begin @(negedge clk); k++; end
    check("t27_mem_read_up", mem_read, 1);
    #2 rst = 1'b1;
    #1;
    check("t27_mem_read_async", mem_read, 0);
    check("t27_resp_valid", resp_valid, 0);
    check("t27_counters", {hit_count, miss_count}, 0);
    check("t27_mem_addr", mem_addr, 0);
    repeat (2) begin
      @(negedge clk);
      check("t27_no_resp", resp_valid, 0);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("t27_no_resp_after", resp_valid, 0);
    do_req(1'b0, 32'h0000_2040, '0, 1'b0, h, nwb, nrd);
    check("t27_prior_miss", h, 0);

    // req_valid held across a miss is accepted once.
    do_req(1'b0, 32'h0000_5080, '0, 1'b1, h, nwb, nrd);
    check("t28_miss", h, 0);
    repeat (4) begin
      @(negedge clk);
      check("t28_single_resp", resp_valid, 0);
    end
    check("t28_miss_count", miss_count, 2);

    // Random traffic over a few sets and tags.
    for (int n = 0; n < 150; n++) begin
      tgi = $urandom_range(0, 5);
      a = {(tgi == 5) ? 22'h3F_FFFF : 22'(tgi), 4'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      do_req(1'($urandom_range(0, 9) < 3), a, rand_line(), bit'($urandom_range(0, 7) == 0), h, nwb, nrd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
